// File: rtl/alarm_ctrl_if.sv
// Signal bundle between the watch/host side and alarm_ctrl: current BCD time,
// alarm load bus, user controls and alarm status/tone outputs.
interface alarm_ctrl_if;
  logic [3:0] hourdec_now;
  logic [3:0] hourone_now;
  logic [3:0] mindec_now;
  logic [3:0] minone_now;
  logic       alarm_en;
  logic       alarm_load;
  logic [3:0] alarm_hourdec_in;
  logic [3:0] alarm_hourone_in;
  logic [3:0] alarm_mindec_in;
  logic [3:0] alarm_minone_in;
  logic       stop;
  logic       snooze;
  logic [3:0] alarm_hourdec;
  logic [3:0] alarm_hourone;
  logic [3:0] alarm_mindec;
  logic [3:0] alarm_minone;
  logic       load_err;
  logic       ringing;
  logic       snoozing;
  logic       tone_out;

  modport master (
    output hourdec_now, hourone_now, mindec_now, minone_now,
    output alarm_en, alarm_load,
    output alarm_hourdec_in, alarm_hourone_in, alarm_mindec_in, alarm_minone_in,
    output stop, snooze,
    input  alarm_hourdec, alarm_hourone, alarm_mindec, alarm_minone,
    input  load_err, ringing, snoozing, tone_out
  );

  modport slave (
    input  hourdec_now, hourone_now, mindec_now, minone_now,
    input  alarm_en, alarm_load,
    input  alarm_hourdec_in, alarm_hourone_in, alarm_mindec_in, alarm_minone_in,
    input  stop, snooze,
    output alarm_hourdec, alarm_hourone, alarm_mindec, alarm_minone,
    output load_err, ringing, snoozing, tone_out
  );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm controller: stores a BCD HH:MM alarm, rings with a gated square-wave tone on match.
// Define ALARM_SNOOZE_EN to build the snooze input and SNOOZE state.
module alarm_ctrl #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned TONE_HZ    = 2000,
  parameter int unsigned BEEP_MS    = 250,
  parameter int unsigned RING_MIN   = 1,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input logic        clk,
  input logic        rst,
  alarm_ctrl_if.slave bus
);

  localparam int unsigned HALF     = CLK_HZ / (2 * TONE_HZ);
  localparam int unsigned BEEP_CYC = CLK_HZ / 1000 * BEEP_MS;
  localparam int unsigned HALF_W   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned BEEP_W   = $clog2(2 * BEEP_CYC);
  localparam logic [3:0]  RING_LIM = 4'(RING_MIN);

`ifdef ALARM_SNOOZE_EN
  localparam logic [3:0]  SNZ_LIM  = 4'(SNOOZE_MIN);
  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RING} state_t;
`endif

  state_t            state;
  logic [3:0]        al_hd, al_ho, al_md, al_mo;
  logic [3:0]        minone_q;
  logic              primed;
  logic              match_q;
  logic              load_err_q;
  logic [3:0]        ring_cnt;
  logic [3:0]        ring_inc;
  logic              ringing_q;
  logic              snoozing_q;
  logic [HALF_W-1:0] half_cnt;
  logic [BEEP_W-1:0] beep_cnt;
  logic              tone_phase;

  logic              load_ok;
  logic              load_valid;
  logic              min_tick;
  logic              match;
  logic              trig;
  logic              leave;

`ifdef ALARM_SNOOZE_EN
  logic [3:0]        snz_cnt;
  logic [3:0]        snz_inc;
`endif

  always_comb begin
    load_ok = (bus.alarm_hourdec_in <= 4'd2) && (bus.alarm_hourone_in <= 4'd9) &&
              !((bus.alarm_hourdec_in == 4'd2) && (bus.alarm_hourone_in > 4'd3)) &&
              (bus.alarm_mindec_in <= 4'd5) && (bus.alarm_minone_in <= 4'd9);
    load_valid = bus.alarm_load && load_ok;
    min_tick   = primed && (bus.minone_now != minone_q);
    match      = (bus.hourdec_now == al_hd) && (bus.hourone_now == al_ho) &&
                 (bus.mindec_now == al_md) && (bus.minone_now == al_mo);
    trig       = match && !match_q && bus.alarm_en;
    // Higher-priority exits shared by RING and SNOOZE
    leave      = load_valid || bus.stop || !bus.alarm_en;
    ring_inc   = (ring_cnt == 4'hF) ? 4'hF : ring_cnt + 4'd1;
`ifdef ALARM_SNOOZE_EN
    snz_inc    = (snz_cnt == 4'hF) ? 4'hF : snz_cnt + 4'd1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      al_hd      <= 4'd0;
      al_ho      <= 4'd7;
      al_md      <= 4'd0;
      al_mo      <= 4'd0;
      load_err_q <= 1'b0;
      minone_q   <= '0;
      primed     <= 1'b0;
      match_q    <= 1'b1;
    end else begin
      if (load_valid) begin
        al_hd <= bus.alarm_hourdec_in;
        al_ho <= bus.alarm_hourone_in;
        al_md <= bus.alarm_mindec_in;
        al_mo <= bus.alarm_minone_in;
      end
      load_err_q <= bus.alarm_load && !load_ok;
      minone_q   <= bus.minone_now;
      primed     <= 1'b1;
      // A freshly loaded time must not ring within the minute it was loaded
      match_q    <= load_valid ? 1'b1 : match;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ring_cnt   <= '0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!load_valid && trig) begin
            state     <= RING;
            ring_cnt  <= '0;
            ringing_q <= 1'b1;
          end
        end
        RING: begin
          if (leave) begin
            state     <= IDLE;
            ringing_q <= 1'b0;
`ifdef ALARM_SNOOZE_EN
          end else if (bus.snooze) begin
            state      <= SNOOZE;
            snz_cnt    <= '0;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b1;
`endif
          end else if (min_tick) begin
            if (ring_inc >= RING_LIM) begin
              state     <= IDLE;
              ringing_q <= 1'b0;
            end else begin
              ring_cnt <= ring_inc;
            end
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (leave) begin
            state      <= IDLE;
            snoozing_q <= 1'b0;
          end else if (min_tick) begin
            if (snz_inc >= SNZ_LIM) begin
              state      <= RING;
              ring_cnt   <= '0;
              ringing_q  <= 1'b1;
              snoozing_q <= 1'b0;
            end else begin
              snz_cnt <= snz_inc;
            end
          end
        end
`endif
        default: begin
          state      <= IDLE;
          ringing_q  <= 1'b0;
          snoozing_q <= 1'b0;
        end
      endcase
    end
  end

  // Tone counters free-run only while in RING; any other state parks them at zero
  // so each RING entry starts with a silent half-period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_cnt   <= '0;
      beep_cnt   <= '0;
      tone_phase <= 1'b0;
    end else if (state != RING) begin
      half_cnt   <= '0;
      beep_cnt   <= '0;
      tone_phase <= 1'b0;
    end else begin
      if (half_cnt == HALF_W'(HALF - 1)) begin
        half_cnt   <= '0;
        tone_phase <= ~tone_phase;
      end else begin
        half_cnt <= half_cnt + 1'b1;
      end
      if (beep_cnt == BEEP_W'(2 * BEEP_CYC - 1)) begin
        beep_cnt <= '0;
      end else begin
        beep_cnt <= beep_cnt + 1'b1;
      end
    end
  end

  assign bus.alarm_hourdec = al_hd;
  assign bus.alarm_hourone = al_ho;
  assign bus.alarm_mindec  = al_md;
  assign bus.alarm_minone  = al_mo;
  assign bus.load_err      = load_err_q;
  assign bus.ringing       = ringing_q;
`ifdef ALARM_SNOOZE_EN
  assign bus.snoozing      = snoozing_q;
`else
  assign bus.snoozing      = 1'b0;
`endif
  assign bus.tone_out      = (state == RING) && tone_phase && (beep_cnt < BEEP_W'(BEEP_CYC));

endmodule
